// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and types for the sequential multiplier peripheral
package mult_pkg;

    localparam int BUS_WIDTH = 16;

    localparam logic [3:0] ADDR_A      = 4'h0;
    localparam logic [3:0] ADDR_B      = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h6;
    localparam logic [3:0] ADDR_PP_LO  = 4'h8;
    localparam logic [3:0] ADDR_PP_HI  = 4'hA;

    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult_core.sv
// rtl/mult_core.sv - radix-2 shift-add multiply engine with IDLE/CALC/DONE control
module mult_core
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [2*WIDTH-1:0]   acc_sum;

    // State and datapath registers; reset aborts any running operation with nothing left behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and shift-add step; the product register is only written on the last step.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = done_q;
        busy_d    = busy_q;
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                // Starts arriving here are dropped on purpose: no restart mid-operation.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    product_d = acc_sum;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: rtl/peripheral_mult_seq.sv
// rtl/peripheral_mult_seq.sv - J1 I/O bus wrapper: operand registers, start pulse and read mux
module peripheral_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              cs,
    input  logic [3:0]        addr,
    input  logic              rd,
    input  logic              wr,
    output logic [WIDTH-1:0]  d_out
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               wr_en;
    logic               rd_en;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   status;

    assign wr_en = cs & wr;
    assign rd_en = cs & rd;

    // Start is a single-edge pulse; the core samples a_q/b_q before this edge's operand writes land.
    assign start = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START_BIT];

    // Operand register next-state from bus writes.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_en) begin
            case (addr)
                ADDR_A:  a_d = d_in;
                ADDR_B:  b_d = d_in;
                default: ;
            endcase
        end
    end

    // Operand registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    mult_core #(
        .WIDTH   (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_q),
        .b       (b_q),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // STATUS word assembled from the core flags.
    always_comb begin
        status                  = '0;
        status[STATUS_DONE_BIT] = done;
        status[STATUS_BUSY_BIT] = busy;
    end

    // Combinational read mux; returns zero when not selected so it can be OR-ed into the SoC mux.
    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                ADDR_A:      d_out = a_q;
                ADDR_B:      d_out = b_q;
                ADDR_STATUS: d_out = status;
                ADDR_PP_LO:  d_out = product[WIDTH-1:0];
                ADDR_PP_HI:  d_out = product[2*WIDTH-1:WIDTH];
                default:     d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_mult_seq.sv
// tb/tb_peripheral_mult_seq.sv - directed self-checking bench for peripheral_mult_seq
module tb_peripheral_mult_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;

    int total;
    int bad;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[8];

    peripheral_mult_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; d_in = 16'h0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        #1;
        d = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_done(input int start_n, output int n, output bit ok);
        logic [15:0] s;
        n  = start_n;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd_reg(4'h6, s);
            if (s == 16'h0001) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
        logic [15:0] lo, hi;
        int n;
        bit ok;
        bus_write(4'h0, a);
        bus_write(4'h2, b);
        bus_write(4'h4, 16'h0001);
        wait_done(0, n, ok);
        check("done_seen", {31'd0, ok}, 32'd1);
        check("latency", n, 32'd16);
        rd_reg(4'h8, lo);
        rd_reg(4'hA, hi);
        check("product", {hi, lo}, p);
    endtask

    initial begin
        logic [15:0] r;
        int n;
        bit ok;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[3] = '{16'h1234, 16'h0000, 32'h0000_0000};
        vecs[4] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[6] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
        vecs[7] = '{16'hABCD, 16'h0001, 32'h0000_ABCD};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rd_reg(4'h6, r); check("rst_status", {16'h0, r}, 32'h0);
        rd_reg(4'h8, r); check("rst_pp_lo", {16'h0, r}, 32'h0);
        rd_reg(4'h0, r); check("rst_a", {16'h0, r}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // test 1: per-cycle busy then done
        bus_write(4'h0, 16'h0003);
        bus_write(4'h2, 16'h0005);
        bus_write(4'h4, 16'h0001);
        for (int k = 0; k < 16; k++) begin
            rd_reg(4'h6, r);
            check($sformatf("t1_busy_c%0d", k), {16'h0, r}, 32'h0002);
            @(posedge clk);
            #1;
        end
        rd_reg(4'h6, r);  check("t1_done", {16'h0, r}, 32'h0001);
        rd_reg(4'h8, r);  check("t1_pp_lo", {16'h0, r}, 32'h000F);
        rd_reg(4'hA, r);  check("t1_pp_hi", {16'h0, r}, 32'h0000);

        // table-driven operand vectors
        for (int i = 0; i < 8; i++) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // test 3: writes and restart attempt during CALC
        bus_write(4'h0, 16'h1234);
        bus_write(4'h2, 16'h0010);
        bus_write(4'h4, 16'h0001);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus_write(4'h0, 16'h0002);
        bus_write(4'h2, 16'h0002);
        bus_write(4'h4, 16'h0001);
        rd_reg(4'h6, r);
        check("t3_still_busy", {16'h0, r}, 32'h0002);
        wait_done(7, n, ok);
        check("t3_done_seen", {31'd0, ok}, 32'd1);
        check("t3_latency", n, 32'd16);
        rd_reg(4'h8, r); check("t3_pp_lo", {16'h0, r}, 32'h2340);
        rd_reg(4'hA, r); check("t3_pp_hi", {16'h0, r}, 32'h0001);
        rd_reg(4'h0, r); check("t3_a_rb", {16'h0, r}, 32'h0002);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rd_reg(4'h6, r); check("t3_no_restart", {16'h0, r}, 32'h0001);

        // test 4: reset in the middle of CALC
        bus_write(4'h0, 16'h0007);
        bus_write(4'h2, 16'h0009);
        bus_write(4'h4, 16'h0001);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        rd_reg(4'h6, r); check("t4_status", {16'h0, r}, 32'h0);
        rd_reg(4'h8, r); check("t4_pp_lo", {16'h0, r}, 32'h0);
        rd_reg(4'hA, r); check("t4_pp_hi", {16'h0, r}, 32'h0);
        rd_reg(4'h0, r); check("t4_a", {16'h0, r}, 32'h0);
        rd_reg(4'h2, r); check("t4_b", {16'h0, r}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rd_reg(4'h6, r); check("t4_no_done", {16'h0, r}, 32'h0);
        rd_reg(4'h8, r); check("t4_pp_after", {16'h0, r}, 32'h0);

        // test 5: previous product visible during CALC
        run_mult(16'h0003, 16'h0005, 32'h0000_000F);
        bus_write(4'h0, 16'h0002);
        bus_write(4'h2, 16'h0002);
        bus_write(4'h4, 16'h0001);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rd_reg(4'h8, r); check("t5_old_pp", {16'h0, r}, 32'h000F);
        rd_reg(4'h6, r); check("t5_busy", {16'h0, r}, 32'h0002);
        wait_done(8, n, ok);
        check("t5_latency", n, 32'd16);
        rd_reg(4'h8, r); check("t5_new_pp", {16'h0, r}, 32'h0004);

        // test 6: unmapped offsets, cs gating, read-during-write
        bus_write(4'h0, 16'h5A5A);
        rd_reg(4'h4, r); check("t6_rd_ctrl", {16'h0, r}, 32'h0);
        rd_reg(4'hC, r); check("t6_rd_c", {16'h0, r}, 32'h0);
        rd_reg(4'hE, r); check("t6_rd_e", {16'h0, r}, 32'h0);
        cs = 1'b0; rd = 1'b1; addr = 4'h0;
        #1;
        check("t6_rd_nocs", {16'h0, d_out}, 32'h0);
        rd = 1'b0;
        @(negedge clk);
        cs = 1'b0; wr = 1'b1; addr = 4'h0; d_in = 16'h1111;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd_reg(4'h0, r); check("t6_wr_nocs", {16'h0, r}, 32'h5A5A);
        bus_write(4'h8, 16'hFFFF);
        rd_reg(4'h8, r); check("t6_wr_ro", {16'h0, r}, 32'h0004);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'h0; d_in = 16'h3C3C;
        #1;
        check("t6_rdwr_old", {16'h0, d_out}, 32'h5A5A);
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        rd_reg(4'h0, r); check("t6_rdwr_new", {16'h0, r}, 32'h3C3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peripheral_mult_seq.md
Name: peripheral_mult_seq

Overview:
Memory-mapped sequential multiplier peripheral on the J1 I/O bus, selected by the SoC address decoder at page 0x67.
- Takes two 16-bit unsigned operands written by the CPU.
- Computes the 32-bit product with a radix-2 shift-add engine over 16 cycles.
- Exposes the product and a done/busy status for polling reads.
- Fills the multiplier slot of the SoC chip-select/read mux.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH; must equal J1 bus width (16).

Ports:
clk    input   1   system clock, all logic on rising edge
rst    input   1   reset; asynchronous assert, active-low (0 = reset)
d_in   input   16  write data from J1 (j1_io_dout)
cs     input   1   chip select from SoC address decoder
addr   input   4   register offset (j1_io_addr[3:0])
rd     input   1   J1 I/O read strobe
wr     input   1   J1 I/O write strobe
d_out  output  16  read data to SoC read mux

Behaviour:
Register map (offsets on addr):
- 0x0 A, RW: operand A.
- 0x2 B, RW: operand B.
- 0x4 CTRL, W: bit0=1 starts a multiply; other bits ignored. Reads return 0.
- 0x6 STATUS, R: bit0=done, bit1=busy, others 0.
- 0x8 PP_LO, R: product[15:0].
- 0xA PP_HI, R: product[31:16].
- Any other offset: writes ignored, reads return 0.

Bus timing:
- Write takes effect at the rising edge where cs&wr=1.
- d_out is combinational: selected register when cs&rd=1, else 16'h0000.
- If cs&rd&wr are all 1, the read returns the pre-edge value and the write still lands.

Reset (rst=0, asynchronous): A=B=0, product=0, done=0, busy=0, FSM=IDLE, iteration counter=0, d_out=0.

FSM states: IDLE, CALC, DONE.
- IDLE or DONE, on a CTRL write with bit0=1:
  - Latch A into the multiplicand register (zero-extended to 32 bits) and B into the multiplier register.
  - Clear accumulator and counter; done<=0, busy<=1; go to CALC.
- CALC, each edge:
  - If multiplier[0]=1, accumulator += multiplicand (32-bit, no carry-out possible).
  - Multiplicand <<= 1, multiplier >>= 1, counter += 1.
- CALC, when counter==15 on that edge:
  - Product register <= final accumulator; done<=1, busy<=0; go to DONE.
- DONE holds until the next start. Product and done persist until then.

Latency: start captured at edge E0; done=1 and the product are readable in the cycle after edge E16, i.e. 16 cycles.

Boundary rules:
- Start while busy (CALC) is ignored, with no restart.
- A/B writes during CALC update the A/B registers but do not affect the running operation.
- The product register changes only at completion. During CALC it still shows the previous result; done=0.
- Start with A=0 or B=0 still takes the full 16 cycles and yields 0.
- rst low mid-CALC aborts immediately to reset values. No partial product is visible.
- cs=0 means bus strobes have no effect.

Decomposition:
- Package mult_pkg holds:
  - register offset constants (ADDR_A, ADDR_B, ADDR_CTRL, ADDR_STATUS, ADDR_PP_LO, ADDR_PP_HI);
  - FSM state encoding;
  - STATUS bit indices.
- Sub-module mult_core holds the FSM plus shift-add datapath.
  - Inputs: clk, rst, start, a, b.
  - Outputs: busy, done, product[31:0].
- peripheral_mult_seq contains only address decode, A/B registers, start pulse generation and the read mux.

Test Plan:
1. Write A=3, B=5, CTRL=1, then poll STATUS -> busy=1 for 16 cycles; STATUS=0x0001 on cycle 16; PP_LO=0x000F, PP_HI=0x0000.
2. A=0xFFFF, B=0xFFFF, start -> PP_HI=0xFFFE, PP_LO=0x0001, done=1.
3. Start A=0x1234, B=0x0010; at cycle 5 write A=0x0002, B=0x0002 and CTRL=1 -> still completes at cycle 16 with product 0x00012340; no restart occurs; A reads back 0x0002.
4. Start A=7, B=9; drive rst=0 at cycle 8 for 2 cycles -> immediately STATUS=0, PP_LO=PP_HI=0, A=B=0; no done pulse afterwards.
5. Previous product 0x0000000F; start A=2, B=2; read PP_LO at cycle 8 -> 0x000F; after completion -> 0x0004.
6. Reads of offsets 0x4, 0xC and 0xE, and any read with cs=0 -> d_out=0x0000. Writes with cs=0 leave A/B unchanged.
